fetch_pc: RTL

FETCH_PC -- requirements
Module: fetch_pc

---
 rtl/fetch_pc_pkg.sv | 27 ++
 rtl/fetch_pc_if.sv | 27 ++
 rtl/fetch_pc_redirect_buf.sv | 43 ++++
 rtl/fetch_pc.sv | 113 +++++++++++
 4 files changed

// File: rtl/fetch_pc_pkg.sv
// Shared definitions for the fetch PC generator: entry address, redirect
// source encoding, lane-index helper and fetch-width legality check.
package fetch_pc_pkg;

    localparam logic [31:0] ENT_START_DEF = 32'hBFC0_0000;
    localparam int unsigned INST_BYTES    = 4;

    // Where the next pc comes from, in priority order (highest last).
    typedef enum logic [2:0] {
        SRC_HOLD,
        SRC_SEQ,
        SRC_PEND,
        SRC_BRANCH,
        SRC_FLUSH
    } pc_src_e;

    function automatic bit fetch_w_legal(input int unsigned fetch_w);
        return (fetch_w == 1) || (fetch_w == 2) || (fetch_w == 4);
    endfunction

    // Index of the first addressed instruction inside its fetch block.
    function automatic int unsigned lane_idx(input logic [3:0] pc_lo,
                                             input int unsigned fetch_w);
        return 32'(pc_lo[3:2]) & (fetch_w - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_pc_if.sv
// Fetch request bus: redirect controls from the pipeline, grant from
// instruction memory, and the request the fetch stage presents.
interface fetch_pc_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned FETCH_W = 2
);
    logic              stall;
    logic              flush;
    logic [ADDR_W-1:0] new_pc;
    logic              bflag;
    logic [ADDR_W-1:0] baddr;
    logic              gnt;
    logic [ADDR_W-1:0] pc;
    logic              inst_en;
    logic [FETCH_W-1:0] lane_vld;
    logic              excp_iadel;

    modport master (
        input  stall, flush, new_pc, bflag, baddr, gnt,
        output pc, inst_en, lane_vld, excp_iadel
    );

    modport slave (
        output stall, flush, new_pc, bflag, baddr, gnt,
        input  pc, inst_en, lane_vld, excp_iadel
    );
endinterface

// File: rtl/fetch_pc_redirect_buf.sv
// Holds a branch redirect that arrived while the fetch request was not
// transferred; the most recent branch overwrites an older one.
module fetch_pc_redirect_buf #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              pend_vld_o,
    output logic [ADDR_W-1:0] pend_addr_o
);

    logic              vld_q, vld_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Clear wins over set; set while valid simply overwrites the target.
    always_comb begin
        vld_d  = vld_q;
        addr_d = addr_q;
        if (clr_i) begin
            vld_d = 1'b0;
        end else if (set_i) begin
            vld_d  = 1'b1;
            addr_d = addr_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
        end
    end

    assign pend_vld_o  = vld_q;
    assign pend_addr_o = addr_q;

endmodule

// File: rtl/fetch_pc.sv
// Instruction fetch PC generator: sequential block fetch, branch and
// flush redirects, pending-branch capture and address-error detection.
module fetch_pc
    import fetch_pc_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       FETCH_W   = 2,
    parameter logic [ADDR_W-1:0] ENT_START = ADDR_W'(ENT_START_DEF)
) (
    input  logic       clk,
    input  logic       rst_n,
    fetch_pc_if.master bus_if
);

    localparam logic [ADDR_W-1:0] BLK_BYTES = ADDR_W'(INST_BYTES * FETCH_W);
    localparam logic [ADDR_W-1:0] BLK_MASK  = ~(BLK_BYTES - ADDR_W'(1));

    if (!fetch_w_legal(FETCH_W) || (ADDR_W < 4)) begin : g_bad_cfg
        $fatal(1, "fetch_pc: FETCH_W must be 1, 2 or 4 and ADDR_W at least 4");
    end

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  seq_pc;
    logic [ADDR_W-1:0]  pend_addr;
    logic [FETCH_W-1:0] lane_vld;
    logic               pend_vld;
    logic               pend_set;
    logic               pend_clr;
    logic               iadel;
    logic               inst_en;
    logic               xfer;
    int unsigned        lane_ix;
    pc_src_e            src;

    assign iadel   = (pc_q[1:0] != 2'b00);
    assign inst_en = rst_n && !bus_if.stall && !iadel && !bus_if.flush;
    assign xfer    = inst_en && bus_if.gnt;
    assign seq_pc  = (pc_q & BLK_MASK) + BLK_BYTES;
    assign lane_ix = lane_idx(pc_q[3:0], FETCH_W);

    for (genvar i = 0; i < FETCH_W; i++) begin : g_lane
        assign lane_vld[i] = (32'(i) >= lane_ix);
    end

    // Redirect priority: flush, live branch, pending branch, sequential, hold.
    always_comb begin
        src = SRC_HOLD;
        if (bus_if.flush) begin
            src = SRC_FLUSH;
        end else if (xfer) begin
            if (bus_if.bflag) begin
                src = SRC_BRANCH;
            end else if (pend_vld) begin
                src = SRC_PEND;
            end else begin
                src = SRC_SEQ;
            end
        end
    end

    // A branch that cannot steer this cycle is parked until the next transfer.
    always_comb begin
        pc_d     = pc_q;
        pend_set = 1'b0;
        pend_clr = 1'b0;
        case (src)
            SRC_FLUSH: begin
                pc_d     = bus_if.new_pc;
                pend_clr = 1'b1;
            end
            SRC_BRANCH: begin
                pc_d     = bus_if.baddr;
                pend_clr = 1'b1;
            end
            SRC_PEND: begin
                pc_d     = pend_addr;
                pend_clr = 1'b1;
            end
            SRC_SEQ: begin
                pc_d = seq_pc;
            end
            default: begin
                pend_set = bus_if.bflag;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= ENT_START;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_pc_redirect_buf #(
        .ADDR_W (ADDR_W)
    ) u_redirect_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_i       (pend_set),
        .clr_i       (pend_clr),
        .addr_i      (bus_if.baddr),
        .pend_vld_o  (pend_vld),
        .pend_addr_o (pend_addr)
    );

    assign bus_if.pc         = pc_q;
    assign bus_if.inst_en    = inst_en;
    assign bus_if.lane_vld   = lane_vld;
    assign bus_if.excp_iadel = iadel;

endmodule
